// File: rtl/byte_unpack_pipeline.sv
// Gathers four 32-bit beats into a 16-byte bank and presents the full bank as
// one group with a valid/ready handshake.
module byte_unpack_pipeline #(
  parameter int BYTE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*BYTE_W-1:0]   data_in,
  output logic [1:0]            group_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BYTE_W-1:0]     data_out_0,
  output logic [BYTE_W-1:0]     data_out_1,
  output logic [BYTE_W-1:0]     data_out_2,
  output logic [BYTE_W-1:0]     data_out_3,
  output logic [BYTE_W-1:0]     data_out_4,
  output logic [BYTE_W-1:0]     data_out_5,
  output logic [BYTE_W-1:0]     data_out_6,
  output logic [BYTE_W-1:0]     data_out_7,
  output logic [BYTE_W-1:0]     data_out_8,
  output logic [BYTE_W-1:0]     data_out_9,
  output logic [BYTE_W-1:0]     data_out_10,
  output logic [BYTE_W-1:0]     data_out_11,
  output logic [BYTE_W-1:0]     data_out_12,
  output logic [BYTE_W-1:0]     data_out_13,
  output logic [BYTE_W-1:0]     data_out_14,
  output logic [BYTE_W-1:0]     data_out_15
);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [1:0]         next_idx;
  logic               accept;
  logic [BYTE_W-1:0]  bank [16];

  // Ready never looks at in_valid; FULL passes the consumer's ready through.
  always_comb begin
    in_ready = 1'b0;
    if (clear) begin
      in_ready = 1'b0;
    end else begin
      case (state)
        COLLECT: in_ready = 1'b1;
        FULL:    in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready;

  // Next-state and beat-index logic; clear overrides both handshakes.
  always_comb begin
    next_state = state;
    next_idx   = group_idx;
    if (clear) begin
      next_state = COLLECT;
      next_idx   = 2'd0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (group_idx == 2'd3) begin
              next_state = FULL;
              next_idx   = 2'd0;
            end else begin
              next_idx = group_idx + 2'd1;
            end
          end else begin
            next_idx = group_idx;
          end
        end
        FULL: begin
          if (out_ready) begin
            next_state = COLLECT;
            next_idx   = in_valid ? 2'd1 : 2'd0;
          end else begin
            next_state = FULL;
          end
        end
        default: begin
          next_state = COLLECT;
          next_idx   = 2'd0;
        end
      endcase
    end
  end

  // State and beat-index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= COLLECT;
      group_idx <= 2'd0;
    end else begin
      state     <= next_state;
      group_idx <= next_idx;
    end
  end

  // Byte bank: an accepted beat lands MSB-first in lanes 4k..4k+3.
  // In FULL group_idx is already 0, so a pass-through beat fills lanes 0-3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        bank[i] <= {BYTE_W{1'b0}};
      end
    end else if (accept) begin
      for (int j = 0; j < 4; j++) begin
        bank[{group_idx, 2'(j)}] <= data_in[(3-j)*BYTE_W +: BYTE_W];
      end
    end
  end

  assign out_valid   = (state == FULL);

  assign data_out_0  = bank[0];
  assign data_out_1  = bank[1];
  assign data_out_2  = bank[2];
  assign data_out_3  = bank[3];
  assign data_out_4  = bank[4];
  assign data_out_5  = bank[5];
  assign data_out_6  = bank[6];
  assign data_out_7  = bank[7];
  assign data_out_8  = bank[8];
  assign data_out_9  = bank[9];
  assign data_out_10 = bank[10];
  assign data_out_11 = bank[11];
  assign data_out_12 = bank[12];
  assign data_out_13 = bank[13];
  assign data_out_14 = bank[14];
  assign data_out_15 = bank[15];

endmodule

// File: tb/tb_byte_unpack_pipeline.sv
// Directed and randomized checks of byte_unpack_pipeline against hand-computed
// values and a small handshake model.
module tb_byte_unpack_pipeline;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] data_in;
  wire         in_ready;
  wire         out_valid;
  wire  [1:0]  group_idx;
  wire  [7:0]  d0, d1, d2, d3, d4, d5, d6, d7;
  wire  [7:0]  d8, d9, d10, d11, d12, d13, d14, d15;
  wire  [127:0] dout = {d15, d14, d13, d12, d11, d10, d9, d8,
                        d7, d6, d5, d4, d3, d2, d1, d0};

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] SEQ16 = 128'h0F0E0D0C0B0A09080706050403020100;

  byte_unpack_pipeline #(.BYTE_W(8)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .group_idx(group_idx), .out_valid(out_valid), .out_ready(out_ready),
    .data_out_0(d0), .data_out_1(d1), .data_out_2(d2), .data_out_3(d3),
    .data_out_4(d4), .data_out_5(d5), .data_out_6(d6), .data_out_7(d7),
    .data_out_8(d8), .data_out_9(d9), .data_out_10(d10), .data_out_11(d11),
    .data_out_12(d12), .data_out_13(d13), .data_out_14(d14), .data_out_15(d15)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int s);
    return (32'(s) * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  function automatic logic [127:0] grp(input int g);
    logic [127:0] r;
    logic [31:0]  w;
    r = 128'd0;
    for (int j = 0; j < 4; j++) begin
      w = word_of(4*g + j);
      for (int b = 0; b < 4; b++) r[(4*j+b)*8 +: 8] = w[(3-b)*8 +: 8];
    end
    return r;
  endfunction

  logic [31:0] w1 [4] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
  logic [31:0] w3 [4] = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};
  logic [31:0] w4 [4] = '{32'h40414243, 32'h50515253, 32'h60616263, 32'h70717273};

  initial begin
    logic m_full;
    logic [1:0] m_idx;
    logic exp_ready;
    logic acc;
    int seq, groups, cycles;

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = 32'd0;
    #12;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_bank", dout, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_group_idx", 128'(group_idx), 128'd0);

    // Back-to-back group, consumer ready
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t1_idx", 128'(group_idx), 128'(k));
      check("t1_ov_low", 128'(out_valid), 128'd0);
      in_valid = 1'b1; data_in = w1[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("t1_ov", 128'(out_valid), 128'd1);
    check("t1_idx_wrap", 128'(group_idx), 128'd0);
    check("t1_bank", dout, SEQ16);
    @(negedge clk);
    check("t1_consumed", 128'(out_valid), 128'd0);

    // Backpressure with a pending beat, then pass-through accept
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; data_in = w1[k];
      @(negedge clk);
    end
    data_in = 32'hFFFFFFFF;
    repeat (5) begin
      #1;
      check("t2_in_ready_low", 128'(in_ready), 128'd0);
      check("t2_ov_hold", 128'(out_valid), 128'd1);
      check("t2_bank_hold", dout, SEQ16);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("t2_in_ready_pass", 128'(in_ready), 128'd1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check("t2_ov_drop", 128'(out_valid), 128'd0);
    check("t2_idx", 128'(group_idx), 128'd1);
    check("t2_bank", dout, {SEQ16[127:32], 32'hFFFFFFFF});
    clear = 1'b1;
    #1;
    check("t2_clear_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    clear = 1'b0;
    check("t2_clear_idx", 128'(group_idx), 128'd0);

    // Beats separated by idle cycles
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; data_in = w3[k];
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) begin
        check("t3_ov", 128'(out_valid), 128'(k == 3));
        check("t3_idx", 128'(group_idx), 128'((k + 1) % 4));
        @(negedge clk);
      end
    end
    check("t3_byte12", 128'(d12), 128'h0D0);
    check("t3_byte15", 128'(d15), 128'h0D3);
    check("t3_byte0", 128'(d0), 128'h0A0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t3_consumed", 128'(out_valid), 128'd0);

    // Clear after two beats; clear beats accept
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; data_in = 32'h11111111 * 32'(k + 1);
      @(negedge clk);
    end
    check("t4_idx_pre", 128'(group_idx), 128'd2);
    clear = 1'b1; in_valid = 1'b1; data_in = 32'h33333333;
    #1;
    check("t4_clear_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    clear = 1'b0;
    check("t4_idx_clr", 128'(group_idx), 128'd0);
    check("t4_ov_clr", 128'(out_valid), 128'd0);
    for (int k = 0; k < 4; k++) begin
      check("t4_ov_low", 128'(out_valid), 128'd0);
      in_valid = 1'b1; data_in = w4[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("t4_ov", 128'(out_valid), 128'd1);
    check("t4_lo", 128'(dout[31:0]), 128'h43424140);
    check("t4_hi", 128'(dout[127:96]), 128'h73727170);

    // Asynchronous reset while FULL
    #2;
    reset = 1'b1;
    #1;
    check("t5_ov", 128'(out_valid), 128'd0);
    check("t5_idx", 128'(group_idx), 128'd0);
    check("t5_bank", dout, 128'd0);
    @(negedge clk);
    reset = 1'b0;

    // Random handshakes against a reference model
    m_full = 1'b0; m_idx = 2'd0; seq = 0; groups = 0; cycles = 0;
    while (groups < 1000 && cycles < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      data_in   = word_of(seq);
      exp_ready = m_full ? out_ready : 1'b1;
      #1;
      check("rnd_in_ready", 128'(in_ready), 128'(exp_ready));
      check("rnd_ov", 128'(out_valid), 128'(m_full));
      check("rnd_idx", 128'(group_idx), 128'(m_idx));
      if (m_full && out_ready) begin
        check("rnd_group", dout, grp(groups));
        groups++;
      end
      acc = in_valid && exp_ready;
      if (m_full) begin
        if (out_ready) begin
          m_full = 1'b0;
          m_idx  = in_valid ? 2'd1 : 2'd0;
        end
      end else if (acc) begin
        if (m_idx == 2'd3) begin
          m_full = 1'b1;
          m_idx  = 2'd0;
        end else begin
          m_idx = m_idx + 2'd1;
        end
      end
      if (acc) seq++;
      cycles++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("rnd_groups_done", 128'(groups), 128'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
